slave_port_sched: RTL
=====================

Name: slave_port_sched

Overview:
- Shares one OBI-style slave port (SRAM bank or peripheral) between MASTERS requesters.
- Arbitrates address phases round-robin and holds the winner stable until the slave grants.
- Records the granted master ID in an in-order FIFO so each response (rvalid/rdata) returns to the correct master.
- Sits in front of each slave of the address-decoding interconnect; replaces per-slave token arbitration wherever a slave may stall or pipeline responses.

Parameters:
- MASTERS, 4, number of requesting ports.
- DATA_WIDTH, 32, data bus width; byte-enable width is DATA_WIDTH/8.
- ADDR_WIDTH, 10, slave-side word/byte address width passed through unchanged.
- MAX_OUTSTANDING, 2, maximum granted transactions awaiting rvalid (>=1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- m_req_i  in  MASTERS  per-master request.
- m_addr_i  in  MASTERS*ADDR_WIDTH  per-master address.
- m_we_i  in  MASTERS  per-master write enable.
- m_be_i  in  MASTERS*DATA_WIDTH/8  per-master byte enables.
- m_wdata_i  in  MASTERS*DATA_WIDTH  per-master write data.
- m_gnt_o  out  MASTERS  address-phase grant, one-hot or zero.
- m_rvalid_o  out  MASTERS  response valid, one-hot or zero.
- m_rdata_o  out  MASTERS*DATA_WIDTH  response data; rdata broadcast to all lanes, qualified by m_rvalid_o.
- s_req_o  out  1  slave request.
- s_addr_o, s_we_o, s_be_o, s_wdata_o  out  ADDR_WIDTH, 1, DATA_WIDTH/8, DATA_WIDTH  muxed address-phase fields of the selected master.
- s_gnt_i  in  1  slave grant.
- s_rvalid_i  in  1  slave response valid; one per granted transaction, for reads and writes.
- s_rdata_i  in  DATA_WIDTH  slave read data.
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current ID FIFO occupancy.
- proto_err_o  out  1  sticky error flag.

Behaviour:
- Reset (synchronous, active-high; clk/reset exactly as above) clears:
  - FIFO and outstanding_o to 0.
  - Priority pointer to 0.
  - State to IDLE.
  - proto_err_o to 0.
  - While reset is high, s_req_o, m_gnt_o and m_rvalid_o are forced to 0.
- Eligibility: s_req_o may assert only when outstanding_o < MAX_OUTSTANDING. A response popping in the same cycle does NOT free a slot that cycle, so there is no rvalid-to-req combinational path.
- Selection: the winner is the first requesting master at or after the priority pointer, wrapping modulo MASTERS. Selection is combinational in IDLE, so a grant can occur in the cycle of the request (0-cycle arbitration latency).
- FSM IDLE:
  - If eligible and any m_req_i is high: drive s_req_o=1 and mux the winner's fields.
  - If s_gnt_i=1: set m_gnt_o[winner]=1, push the winner ID, set pointer=winner+1 (wrapping), stay in IDLE.
  - If s_gnt_i=0: latch the winner into the lock register and go to WAIT_GNT.
- FSM WAIT_GNT:
  - Drive s_req_o=1 with the locked master's fields, ignoring other requests and the pointer.
  - On s_gnt_i: grant the locked master, push its ID, set pointer=locked+1, go to IDLE.
  - If the locked master drops m_req_i (protocol violation): set proto_err_o, deassert s_req_o, go to IDLE with no push.
- Response: when s_rvalid_i=1 and the FIFO is non-empty, set m_rvalid_o[head ID]=1 combinationally, pop the head, and route s_rdata_i.
  - s_rvalid_i with an empty FIFO: set proto_err_o and drop the response.
- Simultaneous push and pop: occupancy is unchanged, and head/tail pointers both advance and wrap modulo MAX_OUTSTANDING.
- A response returns to the master recorded at grant time even if that master has since re-requested.
- Fields of non-selected masters never reach the slave. When s_req_o=0, s_* fields are 0.
- Reset asserted mid-transaction discards outstanding IDs. Responses arriving after reset are flagged as errors once reset deasserts.

Decomposition:
- Shared package holds:
  - the ID width function: clog2 with a minimum of 1, used for MASTERS and MAX_OUTSTANDING.
  - state encoding constants: IDLE=1'b0, WAIT_GNT=1'b1.
- One sub-module: sched_id_fifo, a synchronous FIFO of master IDs with depth MAX_OUTSTANDING, push/pop/count/empty/full.

Test Plan:
- Masters 0 and 2 request with s_gnt_i tied 1, s_rvalid_i 1 cycle after each grant:
  - grants alternate 0,2,0,2;
  - m_rvalid_o alternates 4'b0001/4'b0100 with matching rdata.
- Master 1 requests with s_gnt_i=0 for 3 cycles, and master 0 raises req in cycle 2:
  - s_addr_o stays at master 1's address;
  - gnt goes to master 1 on cycle 4, then to master 0.
- MAX_OUTSTANDING=2, s_rvalid_i held 0, all masters requesting:
  - exactly 2 grants, then s_req_o=0 and outstanding_o=2;
  - one rvalid restores s_req_o on the next cycle.
- Same-cycle grant and response at outstanding_o=1:
  - count stays 1;
  - response goes to the older ID, and the next response to the newer ID.
- s_rvalid_i pulse with an empty FIFO: no m_rvalid_o, proto_err_o=1 and sticky until reset.
- reset pulsed with 2 outstanding: outstanding_o=0, pointer at 0, and the next grant goes to the lowest requesting master.

Source files
------------

// File: rtl/slave_port_sched_pkg.sv
// Shared definitions for the slave port scheduler: ID width helper and FSM states.
package slave_port_sched_pkg;

    // Width of an index into n entries; never less than one bit so that
    // single-entry configurations still get a real register.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Address-phase arbitration states.
    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_GNT = 1'b1
    } sched_state_e;

endpackage

// File: rtl/slave_port_sched_id_fifo.sv
// In-order FIFO of granted master IDs, used to steer responses back to
// the master that owned each address phase.
module sched_id_fifo
    import slave_port_sched_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [WIDTH-1:0]             data_i,
    output logic [WIDTH-1:0]             data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         empty_o,
    output logic                         full_o
);

    localparam int PW = id_width(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two).
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    // Next-state for pointers and occupancy; push and pop together keep count.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wrap_inc(wr_ptr_q);
        if (pop_i)  rd_ptr_d = wrap_inc(rd_ptr_q);
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/slave_port_sched.sv
// Shares one OBI-style slave port between several masters: round-robin
// address-phase arbitration with a locked winner while the slave stalls,
// and an ID FIFO that routes each in-order response to its owner.
//
// Handshake: an address phase completes in the cycle where s_req_o and
// s_gnt_i are both high; the matching m_gnt_o bit is raised in that same
// cycle. A response completes in any cycle where s_rvalid_i is high and is
// delivered via a one-cycle m_rvalid_o pulse; there is no response back-pressure.
module slave_port_sched
    import slave_port_sched_pkg::*;
#(
    parameter int MASTERS         = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 10,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [MASTERS-1:0]                    m_req_i,
    input  logic [MASTERS*ADDR_WIDTH-1:0]         m_addr_i,
    input  logic [MASTERS-1:0]                    m_we_i,
    input  logic [MASTERS*DATA_WIDTH/8-1:0]       m_be_i,
    input  logic [MASTERS*DATA_WIDTH-1:0]         m_wdata_i,
    output logic [MASTERS-1:0]                    m_gnt_o,
    output logic [MASTERS-1:0]                    m_rvalid_o,
    output logic [MASTERS*DATA_WIDTH-1:0]         m_rdata_o,
    output logic                                  s_req_o,
    output logic [ADDR_WIDTH-1:0]                 s_addr_o,
    output logic                                  s_we_o,
    output logic [DATA_WIDTH/8-1:0]               s_be_o,
    output logic [DATA_WIDTH-1:0]                 s_wdata_o,
    input  logic                                  s_gnt_i,
    input  logic                                  s_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                 s_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  outstanding_o,
    output logic                                  proto_err_o
);

    localparam int MIDW = id_width(MASTERS);
    localparam int BEW  = DATA_WIDTH/8;

    sched_state_e    state_q, state_d;
    logic [MIDW-1:0] ptr_q, ptr_d;
    logic [MIDW-1:0] lock_q, lock_d;
    logic            err_q, err_d;

    logic [MIDW-1:0] rr_win;
    logic [MIDW-1:0] sel;
    logic            s_req;
    logic            gnt_hit;
    logic            push;
    logic            pop;
    logic [MIDW-1:0] head_id;
    logic            fifo_empty;
    logic            fifo_full;

    // First requester at or after ptr, wrapping; scanning from the far end
    // down leaves the nearest match as the final assignment.
    function automatic logic [MIDW-1:0] rr_pick(input logic [MASTERS-1:0] req,
                                                input logic [MIDW-1:0]    ptr);
        int idx;
        logic [MIDW-1:0] pick;
        pick = '0;
        for (int i = MASTERS-1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % MASTERS;
            if (req[idx]) pick = MIDW'(idx);
        end
        return pick;
    endfunction

    function automatic logic [MIDW-1:0] next_id(input logic [MIDW-1:0] id);
        return (id == MIDW'(MASTERS-1)) ? '0 : id + MIDW'(1);
    endfunction

    // Arbitration FSM: next state, pointer/lock updates and address-phase controls.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lock_d  = lock_q;
        err_d   = err_q;
        s_req   = 1'b0;
        sel     = '0;
        gnt_hit = 1'b0;
        push    = 1'b0;
        rr_win  = rr_pick(m_req_i, ptr_q);
        case (state_q)
            IDLE: begin
                // fifo_full is registered, so a same-cycle response cannot
                // open a slot: no rvalid-to-req combinational path.
                if (!fifo_full && (|m_req_i)) begin
                    s_req = 1'b1;
                    sel   = rr_win;
                    if (s_gnt_i) begin
                        gnt_hit = 1'b1;
                        push    = 1'b1;
                        ptr_d   = next_id(rr_win);
                    end else begin
                        lock_d  = rr_win;
                        state_d = WAIT_GNT;
                    end
                end
            end
            WAIT_GNT: begin
                sel = lock_q;
                if (m_req_i[lock_q]) begin
                    s_req = 1'b1;
                    if (s_gnt_i) begin
                        gnt_hit = 1'b1;
                        push    = 1'b1;
                        ptr_d   = next_id(lock_q);
                        state_d = IDLE;
                    end
                end else begin
                    // Locked master withdrew before the grant.
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (s_rvalid_i && fifo_empty) err_d = 1'b1;
        if (reset) begin
            s_req   = 1'b0;
            gnt_hit = 1'b0;
            push    = 1'b0;
        end
    end

    // FSM, pointer, lock and sticky error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            lock_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lock_q  <= lock_d;
            err_q   <= err_d;
        end
    end

    assign pop = s_rvalid_i && !fifo_empty && !reset;

    sched_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (MIDW)
    ) u_id_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (sel),
        .data_o  (head_id),
        .count_o (outstanding_o),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // Per-master grant/response steering and gated slave-side field mux.
    always_comb begin
        m_gnt_o    = '0;
        m_rvalid_o = '0;
        s_addr_o   = '0;
        s_we_o     = 1'b0;
        s_be_o     = '0;
        s_wdata_o  = '0;
        for (int i = 0; i < MASTERS; i++) begin
            if (gnt_hit && (sel == MIDW'(i)))  m_gnt_o[i]    = 1'b1;
            if (pop && (head_id == MIDW'(i)))  m_rvalid_o[i] = 1'b1;
            if (s_req && (sel == MIDW'(i))) begin
                s_addr_o  = m_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                s_we_o    = m_we_i[i];
                s_be_o    = m_be_i[i*BEW +: BEW];
                s_wdata_o = m_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign s_req_o     = s_req;
    assign m_rdata_o   = {MASTERS{s_rdata_i}};
    assign proto_err_o = err_q;

endmodule
